// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding scoreboard.
// Default-configuration constants mirror the controller's LOAD_LAT = 2 build.
package hazard_pkg;

    localparam int unsigned MAX_ADDR_W   = 8;
    localparam int unsigned DEF_LOAD_LAT = 2;
    localparam int unsigned SEL_REGFILE  = 0;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    localparam int unsigned DEF_DEPTH = DEF_LOAD_LAT + 1;
    localparam int unsigned DEF_SEL_W = clog2(DEF_DEPTH + 1);

    // dst is stored zero-extended so one entry type serves any ADDR_W up to MAX_ADDR_W
    typedef struct packed {
        logic                  valid;
        logic [MAX_ADDR_W-1:0] dst;
        logic                  is_load;
    } stage_entry_t;

endpackage

// File: rtl/hazard_src_match.sv
// Matches one source operand against every shadow stage and produces its
// forwarding select plus a load-use hazard flag. Purely combinational.
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned SEL_W    = 2
) (
    input  logic [ADDR_W-1:0]        src,
    input  logic                     used,
    input  stage_entry_t [DEPTH-1:0] stages,
    output logic [SEL_W-1:0]         sel,
    output logic                     hazard
);

    logic [MAX_ADDR_W-1:0] src_ext;

    assign src_ext = MAX_ADDR_W'(src);

    // Walk oldest to youngest so the youngest matching stage has the final say.
    always_comb begin
        sel    = SEL_W'(SEL_REGFILE);
        hazard = 1'b0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (used && (src_ext != '0) && stages[k].valid && (stages[k].dst == src_ext)) begin
                if (!stages[k].is_load || (k >= int'(LOAD_LAT))) begin
                    sel    = SEL_W'(k + 1);
                    hazard = 1'b0;
                end else begin
                    sel    = SEL_W'(SEL_REGFILE);
                    hazard = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard_ctrlr.sv
// Hazard/forwarding controller: shadow pipeline of in-flight writers, stall and
// operand-select generation. Optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_scoreboard_ctrlr
    import hazard_pkg::*;
#(
    parameter  int unsigned ADDR_W   = 5,
    parameter  int unsigned LOAD_LAT = 2,
    parameter  int unsigned PERF_W   = 32,
    localparam int unsigned DEPTH    = LOAD_LAT + 1,
    localparam int unsigned SEL_W    = clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              w_issue_valid,
    input  logic [ADDR_W-1:0] w_rs_addr_5,
    input  logic [ADDR_W-1:0] w_rt_addr_5,
    input  logic              w_rs_used,
    input  logic              w_rt_used,
    input  logic [ADDR_W-1:0] w_dst_addr_5,
    input  logic              w_dst_write,
    input  logic              w_dst_is_load,
    input  logic              w_flush,
    input  logic              w_mem_stall,
    input  logic              w_perf_clr,
    output logic              w_stall,
    output logic [SEL_W-1:0]  w_rs_fwd_sel,
    output logic [SEL_W-1:0]  w_rt_fwd_sel,
    output logic [PERF_W-1:0] w_perf_stall_cnt,
    output logic [PERF_W-1:0] w_perf_fwd_cnt
);

    stage_entry_t [DEPTH-1:0] stages_q;
    stage_entry_t             new_entry;
    logic                     rs_hazard;
    logic                     rt_hazard;
    logic                     hazard;

    hazard_src_match #(
        .ADDR_W   (ADDR_W),
        .LOAD_LAT (LOAD_LAT),
        .DEPTH    (DEPTH),
        .SEL_W    (SEL_W)
    ) u_rs_match (
        .src    (w_rs_addr_5),
        .used   (w_rs_used),
        .stages (stages_q),
        .sel    (w_rs_fwd_sel),
        .hazard (rs_hazard)
    );

    hazard_src_match #(
        .ADDR_W   (ADDR_W),
        .LOAD_LAT (LOAD_LAT),
        .DEPTH    (DEPTH),
        .SEL_W    (SEL_W)
    ) u_rt_match (
        .src    (w_rt_addr_5),
        .used   (w_rt_used),
        .stages (stages_q),
        .sel    (w_rt_fwd_sel),
        .hazard (rt_hazard)
    );

    assign hazard  = w_issue_valid & (rs_hazard | rt_hazard);
    assign w_stall = w_mem_stall | hazard;

    always_comb begin
        new_entry = '0;
        if (w_issue_valid && !hazard && !w_flush && w_dst_write && (w_dst_addr_5 != '0)) begin
            new_entry.valid   = 1'b1;
            new_entry.dst     = MAX_ADDR_W'(w_dst_addr_5);
            new_entry.is_load = w_dst_is_load;
        end
    end

    // Last stage simply falls off: the regfile is write-first, so no bypass beyond it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stages_q <= '0;
        end else if (!w_mem_stall) begin
            stages_q <= {stages_q[DEPTH-2:0], new_entry};
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] fwd_cnt_q;
    logic              issued;
    logic              fwd_any;

    assign issued  = w_issue_valid & ~w_stall & ~w_flush;
    assign fwd_any = (w_rs_fwd_sel != SEL_W'(SEL_REGFILE)) |
                     (w_rt_fwd_sel != SEL_W'(SEL_REGFILE));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else if (w_perf_clr) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (w_stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end
            if (issued && fwd_any && (fwd_cnt_q != '1)) begin
                fwd_cnt_q <= fwd_cnt_q + PERF_W'(1);
            end
        end
    end

    assign w_perf_stall_cnt = stall_cnt_q;
    assign w_perf_fwd_cnt   = fwd_cnt_q;
`else
    logic unused_perf_clr;

    assign unused_perf_clr  = w_perf_clr;
    assign w_perf_stall_cnt = '0;
    assign w_perf_fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_ctrlr.sv
// Scoreboard bench for hazard_scoreboard_ctrlr (LOAD_LAT = 2): stimulus pushes
// expected outputs into a queue, a negedge monitor pops and compares.
module tb_hazard_scoreboard_ctrlr;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        w_issue_valid = 1'b0;
    logic [4:0]  w_rs_addr_5 = '0;
    logic [4:0]  w_rt_addr_5 = '0;
    logic        w_rs_used = 1'b0;
    logic        w_rt_used = 1'b0;
    logic [4:0]  w_dst_addr_5 = '0;
    logic        w_dst_write = 1'b0;
    logic        w_dst_is_load = 1'b0;
    logic        w_flush = 1'b0;
    logic        w_mem_stall = 1'b0;
    logic        w_perf_clr = 1'b0;
    logic        w_stall;
    logic [1:0]  w_rs_fwd_sel;
    logic [1:0]  w_rt_fwd_sel;
    logic [31:0] w_perf_stall_cnt;
    logic [31:0] w_perf_fwd_cnt;

    hazard_scoreboard_ctrlr #(
        .ADDR_W   (5),
        .LOAD_LAT (2),
        .PERF_W   (32)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .w_issue_valid    (w_issue_valid),
        .w_rs_addr_5      (w_rs_addr_5),
        .w_rt_addr_5      (w_rt_addr_5),
        .w_rs_used        (w_rs_used),
        .w_rt_used        (w_rt_used),
        .w_dst_addr_5     (w_dst_addr_5),
        .w_dst_write      (w_dst_write),
        .w_dst_is_load    (w_dst_is_load),
        .w_flush          (w_flush),
        .w_mem_stall      (w_mem_stall),
        .w_perf_clr       (w_perf_clr),
        .w_stall          (w_stall),
        .w_rs_fwd_sel     (w_rs_fwd_sel),
        .w_rt_fwd_sel     (w_rt_fwd_sel),
        .w_perf_stall_cnt (w_perf_stall_cnt),
        .w_perf_fwd_cnt   (w_perf_fwd_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        stall;
        logic [1:0]  rs;
        logic [1:0]  rt;
        bit          cp;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    function automatic logic [31:0] pe(input logic [31:0] v);
        return PerfEn ? v : 32'd0;
    endfunction

    task automatic chk(input string nm, input string what, input logic [31:0] act,
                       input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s.%s: got %0d, expected %0d", nm, what, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk(mon_e.name, "stall", {31'd0, w_stall}, {31'd0, mon_e.stall});
            chk(mon_e.name, "rs_sel", {30'd0, w_rs_fwd_sel}, {30'd0, mon_e.rs});
            chk(mon_e.name, "rt_sel", {30'd0, w_rt_fwd_sel}, {30'd0, mon_e.rt});
            if (mon_e.cp) begin
                chk(mon_e.name, "perf_stall", w_perf_stall_cnt, mon_e.sc);
                chk(mon_e.name, "perf_fwd", w_perf_fwd_cnt, mon_e.fc);
            end
        end
    end

    task automatic push(input string nm, input logic es, input logic [1:0] ers,
                        input logic [1:0] ert, input bit cp, input logic [31:0] sc,
                        input logic [31:0] fc);
        exp_t e;
        e.name  = nm;
        e.stall = es;
        e.rs    = ers;
        e.rt    = ert;
        e.cp    = cp;
        e.sc    = pe(sc);
        e.fc    = pe(fc);
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic iv, input logic [4:0] rs, input logic rsu,
                         input logic [4:0] rt, input logic rtu, input logic [4:0] dst,
                         input logic dw, input logic ld, input logic fl, input logic ms);
        w_issue_valid = iv;
        w_rs_addr_5   = rs;
        w_rs_used     = rsu;
        w_rt_addr_5   = rt;
        w_rt_used     = rtu;
        w_dst_addr_5  = dst;
        w_dst_write   = dw;
        w_dst_is_load = ld;
        w_flush       = fl;
        w_mem_stall   = ms;
    endtask

    // One cycle: drive just after the rising edge, expect outputs for this cycle.
    task automatic cyc(input string nm, input logic iv, input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu, input logic [4:0] dst,
                       input logic dw, input logic ld, input logic fl, input logic ms,
                       input logic es, input logic [1:0] ers, input logic [1:0] ert,
                       input bit cp = 1'b0, input logic [31:0] sc = 0,
                       input logic [31:0] fc = 0);
        @(posedge clock);
        #1;
        drive(iv, rs, rsu, rt, rtu, dst, dw, ld, fl, ms);
        push(nm, es, ers, ert, cp, sc, fc);
    endtask

    task automatic idle(input string nm);
        cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        cyc("in_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // ALU result forwarded from stage 0, 1, 2
        cyc("add_r3",     1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0, 0);
        cyc("r3_stage0",  1, 3, 1, 7, 1, 8, 1, 0, 0, 0, 0, 1, 0);
        cyc("r3_stage1",  1, 3, 1, 8, 1, 0, 0, 0, 0, 0, 0, 2, 1);
        cyc("r3_stage2",  1, 3, 1, 8, 1, 0, 0, 0, 0, 0, 0, 3, 2);
        idle("idle_e");

        // load-use: two stall cycles, then forward from last stage
        cyc("lw_r5",      1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0);
        cyc("lu_stall0",  1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 1, 0, 0);
        cyc("lu_stall1",  1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 1, 0, 0);
        cyc("lu_ready",   1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 3, 0);
        cyc("perf_a",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 4);
        idle("idle_k");
        idle("idle_l");

        // youngest writer wins; unmatched source reads regfile
        cyc("add_r4",     1, 1, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0);
        cyc("sub_r4",     1, 1, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0);
        cyc("youngest",   1, 9, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("rt_unused",  1, 4, 1, 4, 0, 0, 0, 0, 0, 0, 0, 2, 0);
        idle("idle_q");

        // r0 never tracked; unused sources never hazard
        cyc("addi_r0",    1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc("use_r0",     1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("lw_r7",      1, 1, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0);
        cyc("r7_unused",  1, 7, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("idle_v");
        idle("idle_w");

        // memory stall freezes stages (flush ignored), then normal load-use
        cyc("lw_r5_b",    1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0);
        cyc("mstall0",    1, 5, 1, 0, 0, 6, 1, 0, 0, 1, 1, 0, 0);
        cyc("mstall1",    1, 5, 1, 0, 0, 6, 1, 0, 0, 1, 1, 0, 0);
        cyc("mstall2_fl", 1, 5, 1, 0, 0, 6, 1, 0, 1, 1, 1, 0, 0);
        cyc("lu_b_s0",    1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 1, 0, 0);
        cyc("lu_b_s1",    1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 1, 0, 0);
        cyc("lu_b_ready", 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        cyc("flush_r6",   1, 1, 1, 0, 0, 6, 1, 0, 1, 0, 0, 0, 0);
        cyc("r6_absent",  1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 7);

        // clear wins over an increment in the same cycle
        cyc("clr_cycle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 7, 7);
        w_perf_clr = 1'b1;
        cyc("lw_r5_c",    1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        w_perf_clr = 1'b0;
        cyc("lu_c_s0",    1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0);

        // async reset in the middle of a load-use stall, no clock edge needed
        @(posedge clock);
        #1;
        drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
        #1;
        reset = 1'b1;
        push("rst_mid", 0, 0, 0, 1, 0, 0);
        cyc("rst_mstall", 1, 5, 1, 0, 0, 6, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0);
        cyc("rst_exit",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        reset = 1'b0;
        cyc("add_r3_b",   1, 1, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        cyc("r3_b_s0",    1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        idle("idle_end");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clock);
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
